// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage load/store path
//   state_t          access FSM states
//   SZ_BYTE/HALF/WORD MemSize encodings (2'b11 behaves as word)
//   DEFAULT_TIMEOUT  default bus timeout in cycles
//   isMisaligned()   alignment check for a size/offset pair
package mem_pkg;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 16;

    // Size code 2'b11 has bit 1 set, so it gets the word alignment rule.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SZ_HALF && offset[0]) || (size[1] && offset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational lane replication, byte enables and load extraction
//   size      in  2   MemSize encoding
//   offset    in  2   byte offset within the word (Addr[1:0])
//   isSigned  in  1   sign-extend loads when set
//   wrData    in  32  right-justified store data
//   rdWord    in  32  raw bus read word
//   laneData  out 32  store data replicated across lanes
//   byteEn    out 4   byte enables, bit i = lane i
//   loadData  out 32  selected lane(s), extended to 32 bits
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        isSigned,
    input  logic [31:0] wrData,
    input  logic [31:0] rdWord,
    output logic [31:0] laneData,
    output logic [3:0]  byteEn,
    output logic [31:0] loadData
);

    logic [7:0]  rdByte;
    logic [15:0] rdHalf;

    always_comb begin
        laneData = size == SZ_BYTE ? {4{wrData[7:0]}} :
                   size == SZ_HALF ? {2{wrData[15:0]}} : wrData;
        byteEn   = size == SZ_BYTE ? 4'b0001 << offset :
                   size == SZ_HALF ? 4'b0011 << offset : 4'b1111;
        rdByte   = rdWord[{offset, 3'b000} +: 8];
        rdHalf   = offset[1] ? rdWord[31:16] : rdWord[15:0];
        loadData = size == SZ_BYTE ? {{24{isSigned & rdByte[7]}}, rdByte} :
                   size == SZ_HALF ? {{16{isSigned & rdHalf[15]}}, rdHalf} : rdWord;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit turning MemRead/MemWrite into a bus transaction
//   clk, reset                 pipeline clock, async active-high reset
//   MemRead, MemWrite          request from EX->MEM (store wins when both set)
//   MemSize, MemSigned         access size and load extension mode
//   Addr, WrData               byte address and right-justified store data
//   RdData, BusErr             load result and timeout flag, valid in DONE
//   Stall                      freezes PC and upstream registers
//   AddrErr                    misaligned request, combinational in IDLE
//   bus_req/we/addr/wdata/be   registered bus request, held until ack
//   bus_rdata, bus_ack         read data sampled on single-cycle ack
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(TIMEOUT);

    state_t        state;
    logic [CW-1:0] count;
    logic [1:0]    sizeQ;
    logic [1:0]    offQ;
    logic          signedQ;
    logic          idle;
    logic          req;
    logic          misaligned;
    logic [31:0]   laneData;
    logic [3:0]    byteEn;
    logic [31:0]   loadData;

    assign idle       = state == IDLE;
    assign req        = MemRead | MemWrite;
    assign misaligned = isMisaligned(MemSize, Addr[1:0]);
    assign AddrErr    = idle && req && misaligned;
    assign Stall      = (idle && req && !misaligned) || state == BUS;

    // The store path is only consumed in IDLE and the load path only in BUS,
    // so one aligner serves both: live inputs in IDLE, latched ones afterwards.
    mem_align uAlign (
        .size     (idle ? MemSize : sizeQ),
        .offset   (idle ? Addr[1:0] : offQ),
        .isSigned (idle ? MemSigned : signedQ),
        .wrData   (WrData),
        .rdWord   (bus_rdata),
        .laneData (laneData),
        .byteEn   (byteEn),
        .loadData (loadData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            sizeQ     <= SZ_BYTE;
            offQ      <= 2'b00;
            signedQ   <= 1'b0;
            RdData    <= '0;
            BusErr    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !misaligned) begin
                        state     <= BUS;
                        count     <= '0;
                        sizeQ     <= MemSize;
                        offQ      <= Addr[1:0];
                        signedQ   <= MemSigned;
                        bus_req   <= 1'b1;
                        bus_we    <= MemWrite;
                        bus_addr  <= {Addr[31:2], 2'b00};
                        bus_wdata <= laneData;
                        bus_be    <= byteEn;
                    end
                end
                BUS: begin
                    // Ack is checked first so it beats a same-cycle timeout.
                    if (bus_ack) begin
                        state   <= DONE;
                        RdData  <= loadData;
                        BusErr  <= 1'b0;
                        bus_req <= 1'b0;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        RdData  <= '0;
                        BusErr  <= 1'b1;
                        bus_req <= 1'b0;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Stall;
    logic        AddrErr;
    logic        BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .Addr      (Addr),
        .WrData    (WrData),
        .RdData    (RdData),
        .Stall     (Stall),
        .AddrErr   (AddrErr),
        .BusErr    (BusErr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load extraction: shift the addressed lane down, then extend.
    function automatic logic [31:0] model(input logic [1:0] sz, input logic [1:0] off,
                                          input logic sgn, input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * off);
        if (sz == 2'b00) return sgn && s[7] ? {24'hFFFFFF, s[7:0]} : {24'h0, s[7:0]};
        if (sz == 2'b01) return sgn && s[15] ? {16'hFFFF, s[15:0]} : {16'h0, s[15:0]};
        return w;
    endfunction

    task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int ackAt,
                          input logic [31:0] rdata, input logic [3:0] expBe,
                          input logic [31:0] expWd);
        exp_t e;
        int bn;
        MemRead   = rd;
        MemWrite  = wr;
        MemSize   = sz;
        MemSigned = sgn;
        Addr      = addr;
        WrData    = wdata;
        bus_rdata = rdata;
        #1;
        chk("stall_detect", Stall, 1'b1);
        chk("addrerr_clear", AddrErr, 1'b0);
        e.rd  = ackAt != 0 ? model(sz, addr[1:0], sgn, rdata) : 32'h0;
        e.err = ackAt == 0;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("bus_req", bus_req, 1'b1);
        chk("bus_we", bus_we, wr);
        chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
        chk("bus_be", bus_be, expBe);
        chk("bus_wdata", bus_wdata, expWd);
        bn = 0;
        while (Stall === 1'b1 && bn < TO + 4) begin
            bn++;
            chk("req_held", bus_req, 1'b1);
            if (bn == ackAt) bus_ack = 1'b1;
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        chk("bus_cycles", 32'(bn), ackAt != 0 ? 32'(ackAt) : 32'(TO));
        e = sb.pop_front();
        chk("done_rddata", RdData, e.rd);
        chk("done_buserr", BusErr, e.err);
        chk("done_req_low", bus_req, 1'b0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk); #1;
        chk("idle_stall", Stall, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemSize   = 2'b10;
        MemSigned = 1'b0;
        Addr      = 32'h0;
        WrData    = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_rddata", RdData, 32'h0);
        chk("rst_buserr", BusErr, 1'b0);
        chk("rst_req", bus_req, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_be", bus_be, 4'h0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_addrerr", AddrErr, 1'b0);
        @(posedge clk); #1;

        access(1, 0, 2'b10, 0, 32'h1000_0004, 32'h0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0);
        access(1, 0, 2'b00, 1, 32'h1000_0003, 32'h0, 1, 32'h8012_3456, 4'b1000, 32'h0);
        access(1, 0, 2'b00, 0, 32'h1000_0003, 32'h0, 2, 32'h8012_3456, 4'b1000, 32'h0);
        access(0, 1, 2'b01, 0, 32'h1000_0002, 32'h0000_ABCD, 3, 32'h0, 4'b1100, 32'hABCD_ABCD);
        access(0, 1, 2'b00, 0, 32'h1000_0001, 32'h0000_005A, 1, 32'h0, 4'b0010, 32'h5A5A_5A5A);
        access(1, 1, 2'b11, 0, 32'h2000_0008, 32'h1234_5678, 2, 32'h0, 4'b1111, 32'h1234_5678);
        access(1, 0, 2'b01, 1, 32'h1000_0002, 32'h0, 1, 32'h8001_7FFF, 4'b1100, 32'h0);
        access(1, 0, 2'b01, 1, 32'h1000_0000, 32'h0, 1, 32'h8001_7FFF, 4'b0011, 32'h0);
        access(1, 0, 2'b10, 0, 32'h1000_0010, 32'h0, 0, 32'h5555_AAAA, 4'b1111, 32'h0);
        access(1, 0, 2'b10, 0, 32'h1000_0014, 32'h0, TO, 32'hCAFE_F00D, 4'b1111, 32'h0);

        // Misaligned word and half loads are refused with no bus activity.
        MemRead = 1'b1;
        MemSize = 2'b10;
        Addr    = 32'h1000_0001;
        #1;
        chk("mis_word_err", AddrErr, 1'b1);
        chk("mis_word_stall", Stall, 1'b0);
        @(posedge clk); #1;
        chk("mis_word_req", bus_req, 1'b0);
        chk("mis_word_hold", AddrErr, 1'b1);
        MemSize = 2'b01;
        Addr    = 32'h1000_0003;
        #1;
        chk("mis_half_err", AddrErr, 1'b1);
        @(posedge clk); #1;
        chk("mis_half_req", bus_req, 1'b0);
        MemRead = 1'b0;
        #1;
        chk("mis_clear", AddrErr, 1'b0);

        // Reset in the middle of a transaction.
        access(1, 0, 2'b10, 0, 32'h1000_0020, 32'h0, 1, 32'h1111_2222, 4'b1111, 32'h0);
        MemRead   = 1'b1;
        MemSize   = 2'b10;
        Addr      = 32'h1000_0024;
        bus_rdata = 32'h3333_4444;
        @(posedge clk); #1;
        chk("mid_req_up", bus_req, 1'b1);
        @(posedge clk); #1;
        MemRead = 1'b0;
        reset   = 1'b1;
        #1;
        chk("mid_rst_req", bus_req, 1'b0);
        chk("mid_rst_stall", Stall, 1'b0);
        chk("mid_rst_rddata", RdData, 32'h0);
        chk("mid_rst_be", bus_be, 4'h0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        @(posedge clk); #1;
        reset   = 1'b0;
        bus_ack = 1'b1;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("late_ack_rddata", RdData, 32'h0);
        chk("late_ack_buserr", BusErr, 1'b0);
        chk("late_ack_req", bus_req, 1'b0);
        chk("late_ack_stall", Stall, 1'b0);

        access(1, 0, 2'b00, 1, 32'h1000_0030, 32'h0, 2, 32'h0000_007F, 4'b0001, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
